// File: rtl/reg_bus_pkg.sv
// Shared types and default sizing for the register-bus scheduler.
package reg_bus_pkg;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StTurn} state_e;

  localparam int unsigned DefNreq = 4;
  localparam int unsigned DefNreg = 4;
  localparam int unsigned DefW    = 4;
  localparam int unsigned DefAw   = 2;

endpackage

// File: rtl/reg_bus_sched_if.sv
// Requester, read-port and register-bank signals of the scheduler, bundled.
interface reg_bus_sched_if #(
  parameter int unsigned NREQ = reg_bus_pkg::DefNreq,
  parameter int unsigned NREG = reg_bus_pkg::DefNreg,
  parameter int unsigned W    = reg_bus_pkg::DefW,
  parameter int unsigned AW   = reg_bus_pkg::DefAw
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ*W-1:0]  wr_data;
  logic [NREQ-1:0]    gnt;
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic               rd_ack;
  logic [W-1:0]       bus_q;
  logic [W-1:0]       rd_data;
  logic [NREG-1:0]    ld;
  logic [NREG-1:0]    oe;
  logic [W-1:0]       bus_d;
  logic               busy;

  modport slave (
    input  req, wr_addr, wr_data, rd_req, rd_addr, bus_q,
    output gnt, rd_ack, rd_data, ld, oe, bus_d, busy
  );

  modport master (
    output req, wr_addr, wr_data, rd_req, rd_addr, bus_q,
    input  gnt, rd_ack, rd_data, ld, oe, bus_d, busy
  );
endinterface

// File: rtl/reg_bus_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  logic [IW-1:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IW'((32'(rr_ptr) + i) % NREQ);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_sched.sv
// Schedules round-robin writes and single-port reads onto a shared tri-state register bank,
// owning every ld/oe strobe and inserting a turnaround cycle after each read.
module reg_bus_sched import reg_bus_pkg::*; #(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned NREG = DefNreg,
  parameter int unsigned W    = DefW,
  parameter int unsigned AW   = DefAw
) (
  input logic             clk,
  input logic             clr,
  reg_bus_sched_if.slave  bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] winner_q, winner_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic [IW-1:0] arb_winner;
  logic          arb_any;
  logic [AW-1:0] wr_sel_addr;
  logic [W-1:0]  wr_sel_data;
  logic          rd_in_range;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  assign wr_sel_addr = bus.wr_addr[winner_q * AW +: AW];
  assign wr_sel_data = bus.wr_data[winner_q * W +: W];
  assign rd_in_range = 32'(rd_addr_q) < NREG;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      winner_q  <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      winner_q  <= winner_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    winner_d  = winner_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    case (state_q)
      StIdle: begin
        // Reads win over writes; the read address is frozen for the whole read.
        if (bus.rd_req) begin
          state_d   = StRead;
          rd_addr_d = bus.rd_addr;
        end else if (arb_any) begin
          state_d  = StWrite;
          winner_d = arb_winner;
        end
      end
      StWrite: begin
        state_d  = StIdle;
        rr_ptr_d = (32'(winner_q) == NREQ - 1) ? '0 : winner_q + 1'b1;
      end
      StRead: begin
        state_d   = StTurn;
        rd_data_d = rd_in_range ? bus.bus_q : '0;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.gnt    = '0;
    bus.ld     = '0;
    bus.oe     = '0;
    bus.bus_d  = '0;
    bus.rd_ack = 1'b0;
    bus.busy   = (state_q != StIdle);
    case (state_q)
      StWrite: begin
        bus.gnt[winner_q] = 1'b1;
        bus.bus_d         = wr_sel_data;
        if (32'(wr_sel_addr) < NREG) bus.ld[wr_sel_addr] = 1'b1;
      end
      StRead: begin
        if (rd_in_range) bus.oe[rd_addr_q] = 1'b1;
      end
      StTurn:  bus.rd_ack = 1'b1;
      default: ;
    endcase
  end

  assign bus.rd_data = rd_data_q;

  a_oe_onehot0: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus.oe));
  a_ld_onehot0: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus.ld));
  a_no_oe_ld:   assert property (@(posedge clk) disable iff (!clr) !((|bus.oe) && (|bus.ld)));
  a_gnt_write:  assert property (@(posedge clk) disable iff (!clr)
                                 (|bus.gnt) |-> (state_q == StWrite));

endmodule

// File: tb/tb_reg_bus_sched.sv
// Directed bench for reg_bus_sched: cycle table on a 4-register bank plus reset and
// out-of-range sequences on a 3-register instance.
module tb_reg_bus_sched;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_bus_sched_if #(.NREQ(4), .NREG(4), .W(4), .AW(2)) bif ();
  reg_bus_sched_if #(.NREQ(4), .NREG(3), .W(4), .AW(2)) bif3 ();

  reg_bus_sched #(.NREQ(4), .NREG(4), .W(4), .AW(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bif)
  );

  reg_bus_sched #(.NREQ(4), .NREG(3), .W(4), .AW(2)) dut3 (
    .clk (clk),
    .clr (clr),
    .bus (bif3)
  );

  // External register bank driven by the scheduler's strobes.
  logic [3:0] bank [4];
  initial for (int r = 0; r < 4; r++) bank[r] = 4'h0;
  always @(posedge clk) for (int r = 0; r < 4; r++) if (bif.ld[r]) bank[r] <= bif.bus_d;
  always_comb begin
    bif.bus_q = 4'h0;
    for (int r = 0; r < 4; r++) if (bif.oe[r]) bif.bus_q = bank[r];
  end
  assign bif3.bus_q = 4'hF;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        rdr;
    logic [1:0]  ra;
    logic [3:0]  gnt;
    logic [3:0]  ld;
    logic [3:0]  oe;
    logic [3:0]  bd;
    logic        ack;
    logic        busy;
    logic [3:0]  rdd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [3:0] rq, input logic [7:0] wa, input logic [15:0] wd,
                     input logic rdr, input logic [1:0] ra, input logic [3:0] g,
                     input logic [3:0] l, input logic [3:0] o, input logic [3:0] bd,
                     input logic ack, input logic bsy, input logic [3:0] rdd);
    vec_t v;
    v = '{rq, wa, wd, rdr, ra, g, l, o, bd, ack, bsy, rdd};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    bif.req = 4'hF;   bif.wr_addr = 8'h39;  bif.wr_data = 16'hDCBA;
    bif.rd_req = 1'b0; bif.rd_addr = 2'd0;
    bif3.req = 4'h0;  bif3.wr_addr = 8'h00; bif3.wr_data = 16'h0000;
    bif3.rd_req = 1'b0; bif3.rd_addr = 2'd0;

    // Cycle table: inputs set at one falling edge, outputs checked at the next.
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h1, 4'h2, 4'h0, 4'hA, 0, 1, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h2, 4'h4, 4'h0, 4'hB, 0, 1, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h4, 4'h8, 4'h0, 4'hC, 0, 1, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h8, 4'h1, 4'h0, 4'hD, 0, 1, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'hF, 8'h39, 16'hDCBA, 0, 0, 4'h1, 4'h2, 4'h0, 4'hA, 0, 1, 4'h0);
    add(4'h9, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'h9, 8'h39, 16'hDCBA, 0, 0, 4'h8, 4'h1, 4'h0, 4'hD, 0, 1, 4'h0);
    add(4'h0, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'h0, 8'h39, 16'hDCBA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'h4, 8'h19, 16'hD7BA, 0, 0, 4'h4, 4'h2, 4'h0, 4'h7, 0, 1, 4'h0);
    add(4'h0, 8'h19, 16'hD7BA, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0);
    add(4'h0, 8'h19, 16'hD7BA, 1, 1, 4'h0, 4'h0, 4'h2, 4'h0, 0, 1, 4'h0);
    add(4'h0, 8'h19, 16'hD7BA, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h7);
    add(4'h0, 8'h19, 16'hD7BA, 0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h7);
    add(4'h4, 8'h29, 16'hD5BA, 1, 3, 4'h0, 4'h0, 4'h8, 4'h0, 0, 1, 4'h7);
    add(4'h4, 8'h29, 16'hD5BA, 0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'hC);
    add(4'h4, 8'h29, 16'hD5BA, 0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'hC);
    add(4'h4, 8'h29, 16'hD5BA, 0, 3, 4'h4, 4'h4, 4'h0, 4'h5, 0, 1, 4'hC);
    add(4'h0, 8'h29, 16'hD5BA, 0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'hC);
    add(4'h3, 8'h29, 16'hD5BA, 1, 2, 4'h0, 4'h0, 4'h4, 4'h0, 0, 1, 4'hC);
    add(4'h3, 8'h29, 16'hD5BA, 0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 4'h5);
    add(4'h3, 8'h29, 16'hD5BA, 0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h5);
    add(4'h3, 8'h29, 16'hD5BA, 0, 2, 4'h1, 4'h2, 4'h0, 4'hA, 0, 1, 4'h5);
    add(4'h0, 8'h29, 16'hD5BA, 0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 4'h5);

    // Held in reset with every requester asking: nothing may move.
    repeat (2) @(negedge clk);
    chk("rst gnt", 32'(bif.gnt), 32'h0);
    chk("rst ld", 32'(bif.ld), 32'h0);
    chk("rst oe", 32'(bif.oe), 32'h0);
    chk("rst ack", 32'(bif.rd_ack), 32'h0);
    chk("rst busy", 32'(bif.busy), 32'h0);
    chk("rst bus_d", 32'(bif.bus_d), 32'h0);
    chk("rst rd_data", 32'(bif.rd_data), 32'h0);
    clr = 1'b1;

    foreach (vq[i]) begin
      bif.req = vq[i].req;     bif.wr_addr = vq[i].wa; bif.wr_data = vq[i].wd;
      bif.rd_req = vq[i].rdr;  bif.rd_addr = vq[i].ra;
      @(negedge clk);
      chk($sformatf("r%0d gnt", i), 32'(bif.gnt), 32'(vq[i].gnt));
      chk($sformatf("r%0d ld", i), 32'(bif.ld), 32'(vq[i].ld));
      chk($sformatf("r%0d oe", i), 32'(bif.oe), 32'(vq[i].oe));
      chk($sformatf("r%0d bus_d", i), 32'(bif.bus_d), 32'(vq[i].bd));
      chk($sformatf("r%0d ack", i), 32'(bif.rd_ack), 32'(vq[i].ack));
      chk($sformatf("r%0d busy", i), 32'(bif.busy), 32'(vq[i].busy));
      chk($sformatf("r%0d rd_data", i), 32'(bif.rd_data), 32'(vq[i].rdd));
    end

    // Reset during READ: oe drops at once, no ack follows, captured data cleared.
    bif.req = 4'h0; bif.rd_req = 1'b1; bif.rd_addr = 2'd1;
    @(posedge clk);
    #2;
    chk("midrst oe before", 32'(bif.oe), 32'h2);
    clr = 1'b0;
    #1;
    chk("midrst oe after", 32'(bif.oe), 32'h0);
    chk("midrst busy", 32'(bif.busy), 32'h0);
    chk("midrst rd_data", 32'(bif.rd_data), 32'h0);
    bif.rd_req = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst no ack %0d", k), 32'(bif.rd_ack), 32'h0);
    end

    // Out-of-range address on the 3-register instance.
    bif3.req = 4'h1; bif3.wr_addr = 8'h03; bif3.wr_data = 16'h0009;
    @(negedge clk);
    chk("oor gnt", 32'(bif3.gnt), 32'h1);
    chk("oor ld", 32'(bif3.ld), 32'h0);
    chk("oor bus_d", 32'(bif3.bus_d), 32'h9);
    bif3.req = 4'h0;
    @(negedge clk);
    bif3.rd_req = 1'b1; bif3.rd_addr = 2'd0;
    @(negedge clk);
    chk("inr oe", 32'(bif3.oe), 32'h1);
    bif3.rd_req = 1'b0;
    @(negedge clk);
    chk("inr ack", 32'(bif3.rd_ack), 32'h1);
    chk("inr rd_data", 32'(bif3.rd_data), 32'hF);
    @(negedge clk);
    bif3.rd_req = 1'b1; bif3.rd_addr = 2'd3;
    @(negedge clk);
    chk("oor oe", 32'(bif3.oe), 32'h0);
    bif3.rd_req = 1'b0;
    @(negedge clk);
    chk("oor ack", 32'(bif3.rd_ack), 32'h1);
    chk("oor rd_data", 32'(bif3.rd_data), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_sched.md
Name: reg_bus_sched

Overview:
- Schedules access to a bank of NREG tri-state 4-bit storage registers that share one data bus.
- Each storage register has three controls: clear, clock-enabled load, and output-enable.
- Up to NREQ write requesters compete for the bank through round-robin arbitration. A single read port drives one register onto the shared bus via its oe.
- The block owns every ld/oe strobe, guarantees at most one oe is active at a time, and inserts a bus turnaround cycle after each read.

Parameters:
- NREQ, 4, number of write requesters (2..8)
- NREG, 4, number of storage registers in the bank (2..16)
- W, 4, data width of each register and of the bus
- AW, 2, register address width; must satisfy 2**AW >= NREG

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  asynchronous, active-low reset
- req  in  NREQ  write request per requester; held high until granted
- wr_addr  in  NREQ*AW  per-requester target register; slice i belongs to requester i
- wr_data  in  NREQ*W  per-requester write data; slice i belongs to requester i
- gnt  out  NREQ  one-hot, 1-cycle pulse: the write of requester i is committed this cycle
- rd_req  in  1  read request; held high until rd_ack
- rd_addr  in  AW  register to read
- rd_ack  out  1  1-cycle pulse: bus_q is valid this cycle
- bus_q  in  W  shared bus as driven by the register bank
- rd_data  out  W  captured read value; holds until the next read
- ld  out  NREG  one-hot load enable to the bank
- oe  out  NREG  one-hot-or-zero output enable to the bank
- bus_d  out  W  write data presented to the bank D inputs
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, rr_ptr=0.
  - gnt, ld, oe, rd_ack, busy, bus_d and rd_data are all 0.
- State IDLE:
  - If rd_req=1, go to READ. Reads have priority over writes.
  - Otherwise, if any req is set, go to WRITE with the winner latched. The winner is the first set req at or after rr_ptr, searching upward and wrapping modulo NREQ.
  - Otherwise stay in IDLE.
- State WRITE (1 cycle):
  - ld[wr_addr[winner]]=1, bus_d=wr_data[winner], gnt[winner]=1.
  - rr_ptr becomes (winner+1) mod NREQ. Next state is IDLE.
  - Write latency is 2 cycles from req sampled in IDLE to the register loaded.
- State READ (1 cycle):
  - oe[rd_addr]=1.
  - At the end of the cycle, rd_data is updated from bus_q.
  - Next state is TURN.
- State TURN (1 cycle):
  - All oe=0 and rd_ack=1.
  - Next state is IDLE.
  - Read latency is 3 cycles from rd_req sampled in IDLE to rd_ack.
- Simultaneous rd_req and req in IDLE: the read is served first and the writes wait. rr_ptr is unchanged by reads.
- Out-of-range address (≥NREG):
  - A write of this kind is still granted, with no ld asserted.
  - A read of this kind still acks, with rd_data=0.
- Requests deasserted early: req and rd_req are sampled only in IDLE. Deasserting them in any other state has no effect on the operation already in progress.
- Invariants checked by assertions:
  - $onehot0(oe) at all times.
  - $onehot0(ld) at all times.
  - oe and ld are never both nonzero in the same cycle.
  - gnt is nonzero only in WRITE.
- Reset mid-operation: all strobes drop immediately. The pending grant or ack is lost, and the requester must re-request.
- rr_ptr wrap-around: after the winner NREQ-1, rr_ptr becomes 0.

Decomposition:
- Shared package reg_bus_pkg holds:
  - state enum {IDLE, WRITE, READ, TURN}
  - default W, NREQ, NREG and AW constants
- Sub-module rr_arbiter (NREQ): combinational round-robin pick.
  - Inputs: req, rr_ptr.
  - Outputs: winner index and an any-request flag.
  - Reused later by other shared-resource blocks.

Test Plan:
- Reset: hold clr=0 with req=4'b1111 -> all outputs stay 0. Release clr -> first grant goes to requester 0.
- Round robin: req=4'b1111 held constantly, re-asserted after each grant -> gnt sequence 0,1,2,3,0. ld follows each requester's wr_addr, and bus_d matches wr_data.
- Write then read: requester 2 writes 4'h7 to reg 1, then rd_req with rd_addr=1 and a bank model on bus_q -> oe=4'b0010 for exactly 1 cycle, rd_ack arrives 2 cycles later, rd_data=4'h7.
- Simultaneous requests: rd_req=1 and req=4'b0100 in the same IDLE cycle -> READ, then TURN, then WRITE for requester 2. oe is all zero during TURN.
- Mid-operation reset: assert clr=0 during READ -> oe drops the same cycle (asynchronously), no rd_ack is produced, and rd_data=0.
- Out-of-range address: NREG=3, write to addr 3 -> gnt pulses with ld=0. Read of addr 3 -> rd_ack with rd_data=0.
